panel_scroll_ctrl: RTL



---
 rtl/panel_scroll_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/panel_scroll_ctrl.sv
// Scroll timing for the LED panel: drives the shared {sel1,sel0} cell-mux select and tracks the scroll offset.
// All outputs registered; a shift code lasts one clk and lands P = TICK_DIV >> speed clks after start.
module panel_scroll_ctrl #(
   parameter int TICK_DIV = 8,
   parameter int COLS     = 20,
   parameter int CNT_W    = 26
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     pause,
   input  logic                     step,
   input  logic                     dir,
   input  logic                     loop,
   input  logic [1:0]               speed,
   output logic                     sel1,
   output logic                     sel0,
   output logic [$clog2(COLS)-1:0]  pos,
   output logic                     wrap,
   output logic                     busy
);
   localparam int POS_W = $clog2(COLS);
   localparam int SC_W  = $clog2(COLS + 1);
   localparam logic [CNT_W-1:0] TICK       = CNT_W'(TICK_DIV);
   localparam logic [POS_W-1:0] POS_MAX    = POS_W'(COLS - 1);
   localparam logic [SC_W-1:0]  SHOTS_LAST = SC_W'(COLS - 1);
   localparam logic [SC_W-1:0]  SHOTS_SAT  = SC_W'(COLS);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

   state_t           state;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] last_cnt;
   logic [SC_W-1:0]  shots;
   logic             counting;
   logic             terminal;
   logic             run_shift;
   logic             man_shift;
   logic             do_shift;
   logic             done;
   logic [POS_W-1:0] pos_next;
   logic             wrap_next;

   // The resume cycle (PAUSE + pause) already counts, so a pause/resume costs no period time.
   assign last_cnt  = (TICK >> speed) - CNT_W'(1);
   assign counting  = !stop && ((state == RUN && !pause) || (state == PAUSE && pause));
   assign terminal  = (presc >= last_cnt);
   assign run_shift = counting && terminal;
   assign man_shift = step && !stop && ((state == IDLE && !start) || (state == PAUSE && !pause));
   assign do_shift  = run_shift || man_shift;
   assign done      = run_shift && !loop && (shots >= SHOTS_LAST);

   always_comb begin
      pos_next  = pos;
      wrap_next = 1'b0;
      if (dir) begin
         if (pos == '0) begin
            pos_next  = POS_MAX;
            wrap_next = 1'b1;
         end else begin
            pos_next = pos - POS_W'(1);
         end
      end else begin
         if (pos == POS_MAX) begin
            pos_next  = '0;
            wrap_next = 1'b1;
         end else begin
            pos_next = pos + POS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         shots <= '0;
         sel1  <= 1'b0;
         sel0  <= 1'b1;
         pos   <= '0;
         wrap  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         // Hold code 01 by default; a shift overrides it for exactly one cycle.
         sel1 <= 1'b0;
         sel0 <= 1'b1;
         wrap <= 1'b0;
         if (do_shift) begin
            sel1 <= 1'b1;
            sel0 <= dir;
            pos  <= pos_next;
            wrap <= wrap_next;
         end

         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            presc <= '0;
         end else if (pause && state == RUN) begin
            state <= PAUSE;
         end else if (state == IDLE && start) begin
            state <= RUN;
            busy  <= 1'b1;
            presc <= '0;
            shots <= '0;
         end else if (pause && state == PAUSE) begin
            state <= RUN;
         end

         if (counting) begin
            if (terminal) begin
               presc <= '0;
               if (shots != SHOTS_SAT) shots <= shots + SC_W'(1);
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end else begin
               presc <= presc + CNT_W'(1);
            end
         end
      end
   end

endmodule
